dispatch_stage: RTL
===================

# dispatch_stage

Dispatch stage between rename and the three reservation stations (ALU, branch, LSU). Holds one renamed instruction in a skid register, allocates a ROB entry, and routes it to the reservation station selected by its FU code. Owns the 128-entry physical-register ready table that reservation stations sample at insert time. Updates that table from the completion broadcast, so inserted entries start with correct source-ready bits.

## Interface
Parameters:
- NUM_PREGS, 128, physical registers; table depth.
- ROB_IDX_W, 5, ROB index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rn_valid  in  1  rename presents an instruction
- rn_ready  out  1  stage accepts this cycle
- rn_data  in  rename_data  pd_new, ps1, ps2, imm
- rn_fu  in  2  0=ALU, 1=branch, 2=LSU, 3=none (ROB-only)
- rn_opcode  in  7  opcode
- rn_has_rd  in  1  instruction writes pd_new
- rob_full  in  1  ROB cannot allocate
- rob_tail  in  ROB_IDX_W  index the ROB assigns on allocation
- rob_alloc  out  1  allocate ROB entry this cycle
- rs_full  in  3  per-RS full, bit = FU code
- di_en  out  3  one-hot insert strobe, bit = FU code
- rs_data_out  out  rename_data  buffered rename data
- fu_out  out  2  buffered FU code
- opcode_out  out  7  buffered opcode
- rob_index_out  out  ROB_IDX_W  equals rob_tail
- preg_rtable  out  1 x [0:127]  ready bit per physical register
- wb_valid  in  1  completion broadcast valid
- wb_preg  in  7  completing physical register
- flush  in  1  mispredict recovery; kill buffered instruction

## Operation
- Skid register: buf_valid plus captured rn_data, rn_fu, rn_opcode, rn_has_rd.
- fire = buf_valid & !rob_full & (rn_fu==3 | !rs_full[fu]) & !flush & !hazard. hazard is defined only without the bypass (see Configuration).
- On fire: rob_alloc=1, di_en[fu]=1 (none for fu==3), and buffered fields are driven out.
- Outputs are combinational from the buffer. di_en and rob_alloc are 0 whenever fire=0.
- rn_ready = !flush & (!buf_valid | fire). On rn_valid & rn_ready, the buffer loads. Otherwise, if fire, buf_valid clears.
- Ready table, registered:
  - On fire with has_rd and pd_new != 0, clear bit pd_new.
  - On wb_valid, set bit wb_preg.
  - If the same index is both set and cleared in one cycle, clear wins.
  - Bit 0 is forced to 1 at all times.
- flush:
  - buf_valid clears next edge; no fire that cycle.
  - Ready table still takes wb updates and is otherwise untouched. Rename restores mappings; completion re-sets bits.

## Timing
- Reset, applied at the clock edge:
  - buf_valid=0, every table bit=1.
  - rn_ready=1; rob_alloc=0; di_en=0.
  - fu_out=0, opcode_out=0, rob_index_out=rob_tail, rs_data_out=0.
- Latency: accepted at edge N means insert/allocate during cycle N+1 if not stalled. Full throughput is one instruction per cycle.
- Stall: buffer holds and outputs stay stable. rn_ready=0 until the cycle fire=1.
- Table clear from fire is visible on preg_rtable the cycle after fire.
- wb set: with bypass, visible in the same cycle; without bypass, visible next cycle.
- Reset mid-stall drops the buffered instruction with no allocation.

## Configuration
- DISPATCH_WB_BYPASS_EN defined:
  - preg_rtable[i] = table[i] | (wb_valid & wb_preg==i).
  - hazard=0 always.
  - An instruction whose source completes in its insert cycle enters the RS ready.
- Undefined:
  - preg_rtable = registered table only.
  - hazard = wb_valid & (wb_preg==ps1 | wb_preg==ps2), with ps nonzero. This costs a one-cycle stall, so the RS never misses that wakeup.

## Test plan
- Reset, then ALU add with pd=40, ps1=5, ps2=6, rob_tail=3:
  - Accepted cycle 0; cycle 1 di_en=3'b001, rob_alloc=1, rob_index_out=3.
  - Cycle 2 preg_rtable[40]=0.
- Back-to-back 4 instructions with fu 0,1,2,3:
  - di_en 001, 010, 100, 000 on consecutive cycles.
  - rob_alloc high 4 cycles; rn_ready stays 1.
- rs_full[2]=1 for 3 cycles while an LSU op is buffered:
  - rn_ready=0, no di_en, outputs stable.
  - di_en=100 on the cycle rs_full drops.
- wb_valid, wb_preg=40, in the same cycle an instruction with ps1=40 is buffered:
  - Bypass: fires with preg_rtable[40]=1.
  - No bypass: fires one cycle later with table bit 1.
- flush while a stalled instruction is buffered (rob_full=1):
  - Next cycle buf_valid=0; no rob_alloc ever; table unchanged.
- Simultaneous fire clearing pd=7 and wb_preg=7: bit 7=0 afterwards; instruction writing pd=0 leaves bit 0 at 1.

Source files
------------

// File: rtl/dispatch_stage_if.sv
// Rename-to-dispatch payload type and the bundle of rename, ROB, RS,
// completion and flush signals seen by dispatch_stage.
package dispatch_stage_pkg;
    typedef struct packed {
        logic [6:0]  pd_new;
        logic [6:0]  ps1;
        logic [6:0]  ps2;
        logic [31:0] imm;
    } rename_data_t;
endpackage

interface dispatch_stage_if #(
    parameter int unsigned NUM_PREGS = 128,
    parameter int unsigned ROB_IDX_W = 5
);
    import dispatch_stage_pkg::*;

    logic                 rn_valid;
    logic                 rn_ready;
    rename_data_t         rn_data;
    logic [1:0]           rn_fu;
    logic [6:0]           rn_opcode;
    logic                 rn_has_rd;
    logic                 rob_full;
    logic [ROB_IDX_W-1:0] rob_tail;
    logic                 rob_alloc;
    logic [2:0]           rs_full;
    logic [2:0]           di_en;
    rename_data_t         rs_data_out;
    logic [1:0]           fu_out;
    logic [6:0]           opcode_out;
    logic [ROB_IDX_W-1:0] rob_index_out;
    logic [NUM_PREGS-1:0] preg_rtable;
    logic                 wb_valid;
    logic [6:0]           wb_preg;
    logic                 flush;

    modport master (
        output rn_valid, rn_data, rn_fu, rn_opcode, rn_has_rd,
        output rob_full, rob_tail, rs_full, wb_valid, wb_preg, flush,
        input  rn_ready, rob_alloc, di_en, rs_data_out, fu_out,
        input  opcode_out, rob_index_out, preg_rtable
    );

    modport slave (
        input  rn_valid, rn_data, rn_fu, rn_opcode, rn_has_rd,
        input  rob_full, rob_tail, rs_full, wb_valid, wb_preg, flush,
        output rn_ready, rob_alloc, di_en, rs_data_out, fu_out,
        output opcode_out, rob_index_out, preg_rtable
    );
endinterface

// File: rtl/dispatch_stage.sv
// Dispatch stage: one-entry skid buffer, ROB allocation, RS routing and the
// physical-register ready table. Define DISPATCH_WB_BYPASS_EN for same-cycle wb bypass.
module dispatch_stage #(
    parameter int unsigned NUM_PREGS = 128,
    parameter int unsigned ROB_IDX_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    dispatch_stage_if.slave bus
);
    import dispatch_stage_pkg::*;

    logic                 r_buf_valid;
    rename_data_t         r_data;
    logic [1:0]           r_fu;
    logic [6:0]           r_opcode;
    logic                 r_has_rd;
    logic [NUM_PREGS-1:0] r_table;

    logic                 w_rs_ok;
    logic                 w_hazard;
    logic                 w_fire;
    logic                 w_rn_ready;
    logic                 w_accept;
    logic [2:0]           w_di_en;
    logic [NUM_PREGS-1:0] w_table_next;

    always_comb begin
        w_rs_ok = 1'b1;
        case (r_fu)
            2'd0:    w_rs_ok = !bus.rs_full[0];
            2'd1:    w_rs_ok = !bus.rs_full[1];
            2'd2:    w_rs_ok = !bus.rs_full[2];
            default: w_rs_ok = 1'b1;
        endcase
    end

`ifdef DISPATCH_WB_BYPASS_EN
    logic [NUM_PREGS-1:0] w_wb_onehot;

    always_comb begin
        w_wb_onehot = '0;
        if (bus.wb_valid) w_wb_onehot[bus.wb_preg] = 1'b1;
    end

    assign w_hazard        = 1'b0;
    assign bus.preg_rtable = r_table | w_wb_onehot;
`else
    // Hold one cycle when a source completes now, so the RS sees it ready at insert.
    assign w_hazard = bus.wb_valid &
                      (((r_data.ps1 != '0) && (bus.wb_preg == r_data.ps1)) ||
                       ((r_data.ps2 != '0) && (bus.wb_preg == r_data.ps2)));
    assign bus.preg_rtable = r_table;
`endif

    assign w_fire     = r_buf_valid & !bus.rob_full & w_rs_ok & !bus.flush & !w_hazard;
    assign w_rn_ready = !bus.flush & (!r_buf_valid | w_fire);
    assign w_accept   = bus.rn_valid & w_rn_ready;

    always_comb begin
        w_di_en = '0;
        if (w_fire) begin
            case (r_fu)
                2'd0:    w_di_en = 3'b001;
                2'd1:    w_di_en = 3'b010;
                2'd2:    w_di_en = 3'b100;
                default: w_di_en = 3'b000;
            endcase
        end
    end

    assign bus.rn_ready      = w_rn_ready;
    assign bus.rob_alloc     = w_fire;
    assign bus.di_en         = w_di_en;
    assign bus.rs_data_out   = r_data;
    assign bus.fu_out        = r_fu;
    assign bus.opcode_out    = r_opcode;
    assign bus.rob_index_out = bus.rob_tail;

    // Clear is applied after set so a same-cycle clear wins; p0 is hardwired ready.
    always_comb begin
        w_table_next = r_table;
        if (bus.wb_valid) w_table_next[bus.wb_preg] = 1'b1;
        if (w_fire && r_has_rd && (r_data.pd_new != '0)) w_table_next[r_data.pd_new] = 1'b0;
        w_table_next[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf_valid <= 1'b0;
            r_data      <= '0;
            r_fu        <= '0;
            r_opcode    <= '0;
            r_has_rd    <= 1'b0;
            r_table     <= '1;
        end else begin
            r_table <= w_table_next;
            if (w_accept) begin
                r_buf_valid <= 1'b1;
                r_data      <= bus.rn_data;
                r_fu        <= bus.rn_fu;
                r_opcode    <= bus.rn_opcode;
                r_has_rd    <= bus.rn_has_rd;
            end else if (w_fire || bus.flush) begin
                r_buf_valid <= 1'b0;
            end
        end
    end
endmodule
